// File: rtl/next_serial_sender_pkg.sv
// Shared types and constants for the NeXT ASIC link serial sender.
// Optional feature macro used by this slice: NEXT_SENDER_PRIORITY_EN.
package nextasic_pkg;

  typedef enum logic [1:0] {
    SND_IDLE = 2'd0,
    SND_HDR  = 2'd1,
    SND_GAP  = 2'd2,
    SND_DATA = 2'd3
  } sender_state_t;

  localparam int DEF_PKT_W = 40;
  localparam logic [39:0] AUDIO_REQ_PKT = 40'h07_0000_0000;

endpackage

// File: rtl/next_serial_sender_if.sv
// Packet write handshake between a producer and next_serial_sender.
// With NEXT_SENDER_PRIORITY_EN defined the bus also carries in_prio.
interface next_serial_sender_if #(
  parameter int PKT_W = 40
);
  logic [PKT_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
`ifdef NEXT_SENDER_PRIORITY_EN
  logic             in_prio;

  modport master (output in_data, output in_valid, output in_prio, input in_ready);
  modport slave  (input in_data, input in_valid, input in_prio, output in_ready);
`else
  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
`endif
endinterface

// File: rtl/next_serial_sender_fifo.sv
// Synchronous packet FIFO with full/empty/level; pop of an empty FIFO
// and push into a full FIFO are ignored.
module sender_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/next_serial_sender.sv
// NeXT ASIC link frame transmitter: header slot, idle gap, FIFO-fed data slot.
// NEXT_SENDER_PRIORITY_EN adds a one-entry priority bypass served before the FIFO.
module next_serial_sender
  import nextasic_pkg::*;
#(
  parameter int               PKT_W      = DEF_PKT_W,
  parameter int               FIFO_DEPTH = 4,
  parameter int               GAP        = 3,
  parameter logic [PKT_W-1:0] REQ_PKT    = PKT_W'(AUDIO_REQ_PKT)
) (
  input  logic                          clk,
  input  logic                          rst,
  next_serial_sender_if.slave           in_if,
  input  logic                          req_mode,
  input  logic                          req_tick,
  output logic                          sout,
  output logic                          busy,
  output logic                          data_loss,
  output logic                          tick_missed,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam logic [1:0] S_IDLE = SND_IDLE;
  localparam logic [1:0] S_HDR  = SND_HDR;
  localparam logic [1:0] S_GAP  = SND_GAP;
  localparam logic [1:0] S_DATA = SND_DATA;
  localparam int         CNT_W  = $clog2(PKT_W + GAP + 2);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PKT_W:0]   sh_q, sh_d;
  logic             data_loss_q, tick_missed_q;
  logic             pop, accept, fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty, src_vld;
  logic [PKT_W-1:0] fifo_dout, src_data;

  assign in_if.in_ready = !fifo_full && !rst;
  assign accept         = in_if.in_valid && in_if.in_ready;

`ifdef NEXT_SENDER_PRIORITY_EN
  logic             prio_vld_q;
  logic [PKT_W-1:0] prio_q;
  logic             prio_wr;

  // A prioritised write only bypasses while the priority slot is free.
  assign prio_wr   = accept && in_if.in_prio && !prio_vld_q;
  assign fifo_push = accept && !prio_wr;
  assign fifo_pop  = pop && !prio_vld_q;
  assign src_vld   = prio_vld_q || !fifo_empty;
  assign src_data  = prio_vld_q ? prio_q : fifo_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               prio_vld_q <= 1'b0;
    else if (prio_wr)      prio_vld_q <= 1'b1;
    else if (pop)          prio_vld_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (prio_wr) prio_q <= in_if.in_data;
  end
`else
  assign fifo_push = accept;
  assign fifo_pop  = pop;
  assign src_vld   = !fifo_empty;
  assign src_data  = fifo_dout;
`endif

  sender_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (in_if.in_data),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Each slot runs cnt from its length-1 down to 0; the shift register drains to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: if (req_tick) begin
        sh_d    = req_mode ? {1'b1, REQ_PKT} : '0;
        cnt_d   = CNT_W'(PKT_W);
        state_d = S_HDR;
      end
      S_HDR: begin
        sh_d = {sh_q[PKT_W-1:0], 1'b0};
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(GAP - 1);
          state_d = S_GAP;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          pop     = src_vld;
          sh_d    = src_vld ? {1'b1, src_data} : '0;
          cnt_d   = CNT_W'(PKT_W);
          state_d = S_DATA;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: begin
        sh_d = {sh_q[PKT_W-1:0], 1'b0};
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      sh_q          <= '0;
      data_loss_q   <= 1'b0;
      tick_missed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      data_loss_q   <= in_if.in_valid && !in_if.in_ready;
      tick_missed_q <= req_tick && (state_q != S_IDLE);
    end
  end

  assign sout        = sh_q[PKT_W];
  assign busy        = (state_q != S_IDLE);
  assign data_loss   = data_loss_q;
  assign tick_missed = tick_missed_q;

endmodule

// File: tb/tb_next_serial_sender.sv
// Directed and randomized bench for next_serial_sender against a frame-position model.
module tb_next_serial_sender;
  import nextasic_pkg::*;

  localparam int PKT_W   = 40;
  localparam int DEPTH   = 4;
  localparam int GAPN    = 3;
  localparam int FRAME   = 2*(PKT_W+1) + GAPN;
  localparam int POP_POS = PKT_W + 1 + GAPN;
  localparam logic [PKT_W-1:0] REQ = AUDIO_REQ_PKT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  next_serial_sender_if #(.PKT_W(PKT_W)) bus ();
  logic       req_mode, req_tick, sout, busy, data_loss, tick_missed;
  logic [2:0] fifo_level;

  next_serial_sender #(.PKT_W(PKT_W), .FIFO_DEPTH(DEPTH), .GAP(GAPN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_if       (bus),
    .req_mode    (req_mode),
    .req_tick    (req_tick),
    .sout        (sout),
    .busy        (busy),
    .data_loss   (data_loss),
    .tick_missed (tick_missed),
    .fifo_level  (fifo_level)
  );

  // Reference: position inside the current frame (0 = idle, 1..FRAME = cycles after the tick).
  int               pos;
  logic [PKT_W:0]   hdr_m, dat_m;
  logic [PKT_W-1:0] q [$];
  logic             loss_m, miss_m;
  int               checks = 0;
  int               errors = 0;
  int               frames_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h pos=%0d t=%0t", tag, obs, exp, pos, $time);
    end
  endtask

  function automatic logic exp_sout();
    if (pos == 0)               return 1'b0;
    if (pos <= PKT_W + 1)       return hdr_m[PKT_W - (pos - 1)];
    if (pos <= POP_POS)         return 1'b0;
    return dat_m[PKT_W - (pos - POP_POS - 1)];
  endfunction

  task automatic check_all();
    chk("sout",        64'(sout),        64'(exp_sout()));
    chk("busy",        64'(busy),        64'(pos != 0));
    chk("fifo_level",  64'(fifo_level),  64'(q.size()));
    chk("in_ready",    64'(bus.in_ready), 64'(!rst && q.size() < DEPTH));
    chk("data_loss",   64'(data_loss),   64'(loss_m));
    chk("tick_missed", 64'(tick_missed), 64'(miss_m));
  endtask

  // One clock: model the edge from the inputs presented, then check just after it.
  task automatic step();
    bit full_b;
    full_b = (q.size() >= DEPTH);
    @(posedge clk);
    miss_m = req_tick && (pos != 0);
    loss_m = bus.in_valid && full_b;
    if (pos == POP_POS) begin
      if (q.size() > 0) dat_m = {1'b1, q.pop_front()};
      else              dat_m = '0;
    end
    if (bus.in_valid && !full_b) q.push_back(bus.in_data);
    if (pos == 0) begin
      if (req_tick) begin
        pos   = 1;
        hdr_m = req_mode ? {1'b1, REQ} : '0;
        frames_seen++;
      end
    end else if (pos == FRAME) pos = 0;
    else pos++;
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick_once(input logic mode);
    req_mode = mode;
    req_tick = 1'b1;
    step();
    req_tick = 1'b0;
  endtask

  task automatic push_one(input logic [PKT_W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [PKT_W-1:0] rnd_pkt();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[PKT_W-1:0];
  endfunction

  // Asserts reset between edges, checks the cleared outputs, then releases it.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    pos = 0; q.delete(); loss_m = 1'b0; miss_m = 1'b0;
    hdr_m = '0; dat_m = '0;
    check_all();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    #1 chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    req_mode     = 1'b0;
    req_tick     = 1'b0;
    pos          = 0;
    loss_m       = 1'b0;
    miss_m       = 1'b0;
    hdr_m        = '0;
    dat_m        = '0;
    @(posedge clk);
    apply_reset();

    // Idle tick: all-zero frame, busy for the full frame length.
    tick_once(1'b0);
    run(FRAME + 3);

    // Request header then idle data slot.
    tick_once(1'b1);
    run(FRAME + 2);

    // Queued packet goes out in the data slot.
    push_one(40'h12_3456_789A);
    tick_once(1'b1);
    run(FRAME + 2);

    // Overflow: five back-to-back writes into a depth-4 FIFO.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = rnd_pkt();
      step();
    end
    bus.in_valid = 1'b0;
    run(2);
    for (int f = 0; f < 4; f++) begin
      tick_once(f[0]);
      run(FRAME + 1);
    end

    // Missed tick at T+10, frame unaffected.
    push_one(rnd_pkt());
    tick_once(1'b1);
    run(9);
    req_tick = 1'b1;
    step();
    req_tick = 1'b0;
    run(FRAME);

    // Tick held high: ticks during a frame and on its last cycle are dropped.
    req_mode = 1'b1;
    req_tick = 1'b1;
    run(2*FRAME + 6);
    req_tick = 1'b0;
    run(3);

    // Reset mid-frame with two packets queued, then a clean frame.
    push_one(rnd_pkt());
    push_one(rnd_pkt());
    tick_once(1'b1);
    run(19);
    apply_reset();
    push_one(40'hA5_5A5A_0F0F);
    tick_once(1'b1);
    run(FRAME + 2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid = ($urandom_range(0, 99) < 30);
      bus.in_data  = rnd_pkt();
      req_tick     = ($urandom_range(0, 99) < 4);
      req_mode     = $urandom_range(0, 1) == 1;
      step();
    end
    bus.in_valid = 1'b0;
    req_tick     = 1'b0;
    run(FRAME + 2);

    chk("frames_seen_nonzero", 64'(frames_seen > 10), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

endmodule
